// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory access unit: FSM states, access kinds
// and the LDR/STR opcodes also used by memory_control.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  localparam logic [1:0] FETCH   = 2'b00;
  localparam logic [1:0] LOAD    = 2'b01;
  localparam logic [1:0] STORE   = 2'b10;
  localparam logic [1:0] ILLEGAL = 2'b11;

  localparam logic [3:0] OP_LDR = 4'b1101;
  localparam logic [3:0] OP_STR = 4'b1110;

  function automatic logic [1:0] decode_kind(input logic ld, input logic st);
    logic [1:0] kind;
    case ({ld, st})
      2'b10:   kind = LOAD;
      2'b01:   kind = STORE;
      2'b00:   kind = FETCH;
      default: kind = ILLEGAL;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/mem_access_unit_wait_timer.sv
// Saturating wait-state counter; flags the last allowed cycle before timeout.
module wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  logic [7:0] r_count;

  // Wait counter: clear wins, then saturating increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 8'd0;
    end else if (i_clr) begin
      r_count <= 8'd0;
    end else if (i_en && (r_count != 8'hFF)) begin
      r_count <= r_count + 8'd1;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_expired = (r_count == LP_LAST);

endmodule

// File: rtl/mem_access_unit.sv
// Turns one load/store/fetch request into a registered memory handshake and
// returns the result on a back-pressured response channel.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_ld,
  input  logic              req_st,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_kind,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  state_e            r_state;
  state_e            w_next_state;
  logic [1:0]        w_kind;
  logic [1:0]        r_kind;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              w_expired;
  logic              w_tmr_clr;
  logic              w_tmr_en;

  assign w_kind    = decode_kind(req_ld, req_st);
  assign w_tmr_clr = (r_state != ACCESS);
  assign w_tmr_en  = (r_state == ACCESS) && !mem_ack;

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_tmr_clr),
    .i_en      (w_tmr_en),
    .o_expired (w_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; an ack on the last allowed cycle takes priority over timeout.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_next_state = (w_kind == ILLEGAL) ? RESP : ACCESS;
        end else begin
          w_next_state = IDLE;
        end
      end
      ACCESS: begin
        if (mem_ack || w_expired) begin
          w_next_state = RESP;
        end else begin
          w_next_state = ACCESS;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = RESP;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Output decode: depends only on state and captured kind, so reset drops mem_cs at once.
  always_comb begin
    req_ready = 1'b0;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      IDLE:    req_ready = 1'b1;
      ACCESS: begin
        mem_cs = 1'b1;
        mem_we = (r_kind == STORE);
      end
      RESP:    rsp_valid = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

  // Request capture and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_kind      <= FETCH;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_kind  <= w_kind;
            if (w_kind == ILLEGAL) begin
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            r_rsp_rdata <= (r_kind == STORE) ? '0 : mem_rdata;
            r_rsp_err   <= 1'b0;
          end else if (w_expired) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
          end
        end
        default: begin
          r_rsp_rdata <= r_rsp_rdata;
        end
      endcase
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign rsp_kind  = r_kind;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit plus hand-written
// back-pressure and mid-transaction reset sequences.
module tb_mem_access_unit;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_ld;
  logic          req_st;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          mem_cs;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_kind;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ld(req_ld), .req_st(req_st),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_cs(mem_cs), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_kind(rsp_kind), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        st;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_at;     // ACCESS cycle index (0-based) carrying ack, -1 = never
    logic [31:0] mdata;
    logic [1:0]  kind;
    logic [31:0] rdata;
    logic        err;
    int          cs_cycles;
    int          lat;        // cycles from acceptance edge to rsp_valid
  } vec_t;

  vec_t vecs[7];
  int   n_tests;
  int   n_fail;
  int   cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL [%0d] %s: got 0x%08h, expected 0x%08h", cur, name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   lat;
    int   cs_cnt;
    logic exp_we;
    exp_we = v.st & ~v.ld;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_ld = v.ld; req_st = v.st;
    req_addr  = v.addr; req_wdata = v.wdata;
    @(negedge clk);
    req_valid = 1'b0; req_ld = 1'b0; req_st = 1'b0;
    lat = 1; cs_cnt = 0;
    while (!rsp_valid && lat < 200) begin
      if (mem_cs) begin
        chk("mem_we", 32'(mem_we), 32'(exp_we));
        chk("mem_addr", mem_addr, v.addr);
        chk("mem_wdata", mem_wdata, v.wdata);
        mem_ack   = (cs_cnt == v.ack_at);
        mem_rdata = mem_ack ? v.mdata : (32'hBAD0_0000 | 32'(cs_cnt));
        cs_cnt++;
      end else begin
        mem_ack = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    mem_ack = 1'b0;
    chk("latency", 32'(lat), 32'(v.lat));
    chk("cs_cycles", 32'(cs_cnt), 32'(v.cs_cycles));
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("cs_in_resp", 32'(mem_cs), 32'd0);
    chk("req_ready_resp", 32'(req_ready), 32'd0);
    chk("rsp_kind", 32'(rsp_kind), 32'(v.kind));
    chk("rsp_rdata", rsp_rdata, v.rdata);
    chk("rsp_err", 32'(rsp_err), 32'(v.err));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_after", 32'(rsp_valid), 32'd0);
    chk("req_ready_after", 32'(req_ready), 32'd1);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cur = -1;
    rst_n = 1'b0; req_valid = 1'b0; req_ld = 1'b0; req_st = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0; rsp_ready = 1'b0;

    //            ld    st    addr          wdata         ack  mdata         kind   rdata         err   cs  lat
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0000_0000,  2, 32'hDEAD_BEEF, 2'b01, 32'hDEAD_BEEF, 1'b0,  3,  4};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0204, 32'h1234_5678,  0, 32'hA5A5_A5A5, 2'b10, 32'h0000_0000, 1'b0,  1,  2};
    vecs[2] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0000_0011,  0, 32'hCAFE_F00D, 2'b00, 32'hCAFE_F00D, 1'b0,  1,  2};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0000_0022, -1, 32'h0000_0000, 2'b01, 32'h0000_0000, 1'b1, 15, 16};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0080, 32'h0000_0033, 14, 32'h1357_9BDF, 2'b00, 32'h1357_9BDF, 1'b0, 15, 16};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0444, 32'h0000_0044,  0, 32'hFFFF_FFFF, 2'b11, 32'h0000_0000, 1'b1,  0,  1};
    vecs[6] = '{1'b0, 1'b1, 32'h0000_0600, 32'h8765_4321, 14, 32'h5555_AAAA, 2'b10, 32'h0000_0000, 1'b0, 15, 16};

    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_cs", 32'(mem_cs), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_kind", 32'(rsp_kind), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      cur = i;
      run_vec(vecs[i]);
    end

    // Back-pressure: response held for six cycles, queued request waits for handshake.
    cur = 100;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h0000_0040; req_wdata = 32'd0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp_cs", 32'(mem_cs), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    mem_ack = 1'b0;
    req_valid = 1'b1; req_ld = 1'b1; req_addr = 32'h0000_0500;
    for (int i = 0; i < 6; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_kind", 32'(rsp_kind), 32'd0);
      chk("bp_rsp_rdata", rsp_rdata, 32'h0BAD_F00D);
      chk("bp_rsp_err", 32'(rsp_err), 32'd0);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_cs_low", 32'(mem_cs), 32'd0);
      if (i == 5) rsp_ready = 1'b1;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    chk("bp_rsp_done", 32'(rsp_valid), 32'd0);
    chk("bp_ready_back", 32'(req_ready), 32'd1);
    chk("bp_not_yet", 32'(mem_cs), 32'd0);
    @(negedge clk);
    req_valid = 1'b0; req_ld = 1'b0;
    chk("bp_next_cs", 32'(mem_cs), 32'd1);
    chk("bp_next_addr", mem_addr, 32'h0000_0500);
    chk("bp_next_we", 32'(mem_we), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0001;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("bp_next_valid", 32'(rsp_valid), 32'd1);
    chk("bp_next_kind", 32'(rsp_kind), 32'd1);
    chk("bp_next_rdata", rsp_rdata, 32'h0000_0001);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset during the 2nd ACCESS cycle of a load.
    cur = 101;
    req_valid = 1'b1; req_ld = 1'b1; req_addr = 32'h0000_0700;
    @(negedge clk);
    req_valid = 1'b0; req_ld = 1'b0;
    chk("rr_cs1", 32'(mem_cs), 32'd1);
    @(negedge clk);
    chk("rr_cs2", 32'(mem_cs), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rr_cs_drop", 32'(mem_cs), 32'd0);
    chk("rr_no_rsp", 32'(rsp_valid), 32'd0);
    chk("rr_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hFEED_FACE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rr_ack_ignored_valid", 32'(rsp_valid), 32'd0);
      chk("rr_ack_ignored_cs", 32'(mem_cs), 32'd0);
      chk("rr_ack_ignored_ready", 32'(req_ready), 32'd1);
    end
    mem_ack = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
